// File: rtl/maze_pkg.sv
// Shared definitions for the maze tile map writer: geometry defaults, command
// encodings, FSM states and index/width helpers.
package maze_pkg;

  localparam int ROWS_DEF = 8;
  localparam int COLS_DEF = 8;

  // Power-on pattern; bit index = row*COLS + col, 1 = wall/pellet tile.
  localparam logic [63:0] INIT_MAP_DEF = 64'h3C24_3E21_103F_0000;

  typedef enum logic [1:0] {
    OP_CLR    = 2'b00,
    OP_SET    = 2'b01,
    OP_TGL    = 2'b10,
    OP_RELOAD = 2'b11
  } wr_op_e;

  typedef enum logic {
    LOAD = 1'b0,
    IDLE = 1'b1
  } state_e;

  function automatic int unsigned tile_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned cols);
    return (row * cols) + col;
  endfunction

  function automatic int unsigned bit_width(input int unsigned n);
    return (n > 32'd1) ? $clog2(n) : 32'd1;
  endfunction

endpackage

// File: rtl/maze_map_writer_if.sv
// Command, lookup and status bundle of the maze map writer.
// Carries pellet_cnt/all_clear only when MAZE_PELLET_COUNT_EN is defined.
interface maze_map_writer_if
  import maze_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) ();

  localparam int NCELLS = ROWS * COLS;
  localparam int ROW_W  = bit_width(ROWS);
  localparam int COL_W  = bit_width(COLS);
  localparam int IDX_W  = bit_width(NCELLS);

  logic              wr_valid;
  logic              wr_ready;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [1:0]        wr_op;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;
  logic              rd_bit;
  logic              busy;
  logic [NCELLS-1:0] map_out;
`ifdef MAZE_PELLET_COUNT_EN
  logic [IDX_W:0]    pellet_cnt;
  logic              all_clear;

  modport master (
    output wr_valid, wr_row, wr_col, wr_op, rd_row, rd_col,
    input  wr_ready, rd_bit, busy, map_out, pellet_cnt, all_clear
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_op, rd_row, rd_col,
    output wr_ready, rd_bit, busy, map_out, pellet_cnt, all_clear
  );
`else
  modport master (
    output wr_valid, wr_row, wr_col, wr_op, rd_row, rd_col,
    input  wr_ready, rd_bit, busy, map_out
  );

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_op, rd_row, rd_col,
    output wr_ready, rd_bit, busy, map_out
  );
`endif

endinterface

// File: rtl/maze_map_writer.sv
// Maze tile map: tile-serial (re)load from INIT_MAP, single-tile clear/set/toggle
// commands and a 1-cycle renderer lookup. MAZE_PELLET_COUNT_EN adds a pellet counter.
module maze_map_writer
  import maze_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF,
  parameter logic [ROWS*COLS-1:0] INIT_MAP = (ROWS*COLS)'(INIT_MAP_DEF)
) (
  input logic              clk,
  input logic              rst_n,
  maze_map_writer_if.slave s_bus
);

  localparam int NCELLS = ROWS * COLS;
  localparam int IDX_W  = bit_width(NCELLS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCELLS - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic [NCELLS-1:0] r_map;
  logic [NCELLS-1:0] w_map_nxt;
  logic              r_wr_ready;
  logic              r_busy;
  logic              r_rd_bit;

  wr_op_e            w_op;
  logic              w_accept;
  int unsigned       w_wr_lin;
  int unsigned       w_rd_lin;
  logic              w_wr_hit;
  logic              w_rd_hit;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [IDX_W-1:0]  w_rd_idx;

  assign w_op     = wr_op_e'(s_bus.wr_op);
  assign w_accept = s_bus.wr_valid && r_wr_ready;

  // Linear addresses beyond the map (non-power-of-two geometry) are dropped.
  assign w_wr_lin = tile_idx(32'(s_bus.wr_row), 32'(s_bus.wr_col), 32'(COLS));
  assign w_rd_lin = tile_idx(32'(s_bus.rd_row), 32'(s_bus.rd_col), 32'(COLS));
  assign w_wr_hit = (w_wr_lin < 32'(NCELLS));
  assign w_rd_hit = (w_rd_lin < 32'(NCELLS));
  assign w_wr_idx = IDX_W'(w_wr_lin);
  assign w_rd_idx = IDX_W'(w_rd_lin);

  // Next-state, load index and next map image.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_map_nxt   = r_map;
    case (r_state)
      LOAD: begin
        w_map_nxt[r_idx] = INIT_MAP[r_idx];
        if (r_idx == LAST_IDX) begin
          w_state_nxt = IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + 1'b1;
        end
      end
      IDLE: begin
        if (w_accept && (w_op == OP_RELOAD)) begin
          w_state_nxt = LOAD;
          w_idx_nxt   = '0;
        end else if (w_accept && w_wr_hit) begin
          case (w_op)
            OP_CLR:  w_map_nxt[w_wr_idx] = 1'b0;
            OP_SET:  w_map_nxt[w_wr_idx] = 1'b1;
            OP_TGL:  w_map_nxt[w_wr_idx] = ~r_map[w_wr_idx];
            default: w_map_nxt = r_map;
          endcase
        end else begin
          w_map_nxt = r_map;
        end
      end
      default: begin
        w_state_nxt = LOAD;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // State, map and handshake/status registers; status follows the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= LOAD;
      r_idx      <= '0;
      r_map      <= '0;
      r_wr_ready <= 1'b0;
      r_busy     <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_map      <= w_map_nxt;
      r_wr_ready <= (w_state_nxt == IDLE);
      r_busy     <= (w_state_nxt == LOAD);
    end
  end

  // Renderer lookup samples the pre-write map, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bit <= 1'b0;
    end else begin
      r_rd_bit <= w_rd_hit ? r_map[w_rd_idx] : 1'b0;
    end
  end

  assign s_bus.wr_ready = r_wr_ready;
  assign s_bus.busy     = r_busy;
  assign s_bus.rd_bit   = r_rd_bit;
  assign s_bus.map_out  = r_map;

`ifdef MAZE_PELLET_COUNT_EN
  logic [IDX_W:0] r_pellet_cnt;
  logic [IDX_W:0] w_pellet_nxt;
  logic           r_all_clear;

  assign w_pellet_nxt = (IDX_W + 1)'($countones(w_map_nxt));

  // Pellet count tracks the next map image so it lines up with map_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pellet_cnt <= '0;
      r_all_clear  <= 1'b0;
    end else begin
      r_pellet_cnt <= w_pellet_nxt;
      r_all_clear  <= (r_state == IDLE) && (r_pellet_cnt != '0) && (w_pellet_nxt == '0);
    end
  end

  assign s_bus.pellet_cnt = r_pellet_cnt;
  assign s_bus.all_clear  = r_all_clear;
`endif

endmodule

// File: tb/tb_maze_map_writer.sv
// Directed self-checking bench for maze_map_writer with a reference tile model
// and an expected-value queue; pellet checks build with MAZE_PELLET_COUNT_EN.
module tb_maze_map_writer;
  import maze_pkg::*;

  localparam logic [63:0] INIT = 64'h3C24_3E21_103F_0000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cnt;
  int n_pulse = 0;

  logic [63:0] mdl;
  logic [63:0] old;
  logic [63:0] exp_q[$];

  maze_map_writer_if #(.ROWS(8), .COLS(8)) bus ();

  maze_map_writer #(.ROWS(8), .COLS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .s_bus(bus)
  );

  always #5 clk = ~clk;

`ifdef MAZE_PELLET_COUNT_EN
  always @(negedge clk) begin
    if (bus.all_clear === 1'b1) n_pulse++;
  end
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input string tag, input int row, input int col, input logic [1:0] op);
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'(row);
    bus.wr_col   = 3'(col);
    bus.wr_op    = op;
    case (op)
      2'b00:   mdl[row*8+col] = 1'b0;
      2'b01:   mdl[row*8+col] = 1'b1;
      2'b10:   mdl[row*8+col] = ~mdl[row*8+col];
      default: mdl = mdl;
    endcase
    exp_q.push_back(mdl);
    step();
    bus.wr_valid = 1'b0;
    check(tag, bus.map_out, exp_q.pop_front());
  endtask

  task automatic do_read(input string tag, input int row, input int col);
    bus.rd_row = 3'(row);
    bus.rd_col = 3'(col);
    exp_q.push_back(64'(mdl[row*8+col]));
    step();
    check(tag, 64'(bus.rd_bit), exp_q.pop_front());
  endtask

  task automatic wait_load(input string tag);
    cnt = 0;
    while (bus.busy === 1'b1 && cnt < 200) begin
      step();
      cnt++;
    end
    check(tag, 64'(cnt), 64'd64);
  endtask

  initial begin
    bus.wr_valid = 1'b0;
    bus.wr_row   = 3'd0;
    bus.wr_col   = 3'd0;
    bus.wr_op    = 2'b00;
    bus.rd_row   = 3'd0;
    bus.rd_col   = 3'd0;
    repeat (3) step();
    check("rst_busy",  64'(bus.busy),     64'd1);
    check("rst_ready", 64'(bus.wr_ready), 64'd0);
    check("rst_map",   bus.map_out,       64'd0);
    check("rst_rdbit", 64'(bus.rd_bit),   64'd0);

    rst_n = 1'b1;
    wait_load("load_cycles");
    check("load_map",   bus.map_out,       INIT);
    check("load_ready", 64'(bus.wr_ready), 64'd1);
    mdl = INIT;
`ifdef MAZE_PELLET_COUNT_EN
    check("load_pellets", 64'(bus.pellet_cnt), 64'($countones(INIT)));
`endif

    do_write("clr_r2c3", 2, 3, 2'b00);
    do_read("rd_r2c3", 2, 3);

    // back-to-back toggles of the last tile
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd7;
    bus.wr_col   = 3'd7;
    bus.wr_op    = 2'b10;
    mdl[63] = ~mdl[63];
    step();
    check("tgl1_map",   bus.map_out,       mdl);
    check("tgl1_ready", 64'(bus.wr_ready), 64'd1);
    mdl[63] = ~mdl[63];
    step();
    bus.wr_valid = 1'b0;
    check("tgl2_map",   bus.map_out,       mdl);
    check("tgl2_ready", 64'(bus.wr_ready), 64'd1);

    // write and read tile (1,1) on the same edge
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd1;
    bus.wr_col   = 3'd1;
    bus.wr_op    = 2'b01;
    bus.rd_row   = 3'd1;
    bus.rd_col   = 3'd1;
    exp_q.push_back(64'(mdl[9]));
    mdl[9] = 1'b1;
    step();
    bus.wr_valid = 1'b0;
    check("rbw_old", 64'(bus.rd_bit), exp_q.pop_front());
    check("rbw_map", bus.map_out, mdl);
    do_read("rbw_new", 1, 1);

    // reload, with a set command held during the load
    old = mdl;
    bus.wr_valid = 1'b1;
    bus.wr_row   = 3'd0;
    bus.wr_col   = 3'd0;
    bus.wr_op    = 2'b11;
    step();
    check("reload_busy",  64'(bus.busy),     64'd1);
    check("reload_ready", 64'(bus.wr_ready), 64'd0);
    check("reload_keep",  bus.map_out,       old);
    bus.wr_op  = 2'b01;
    bus.rd_row = 3'd2;
    bus.rd_col = 3'd3;
    cnt = 0;
    while (bus.wr_ready !== 1'b1 && cnt < 200) begin
      step();
      cnt++;
      if (cnt == 10) begin
        check("reload_partial", bus.map_out, (INIT & 64'h3FF) | (old & ~64'h3FF));
        check("reload_rd_old",  64'(bus.rd_bit), 64'(old[19]));
      end
    end
    check("reload_ready_low", 64'(cnt), 64'd64);
    mdl = INIT | 64'd1;
    step();
    bus.wr_valid = 1'b0;
    check("reload_held_cmd", bus.map_out, mdl);

    // reset in the middle of a reload
    bus.wr_valid = 1'b1;
    bus.wr_op    = 2'b11;
    step();
    bus.wr_valid = 1'b0;
    repeat (5) step();
    check("midload_map", bus.map_out, (INIT & 64'h1F) | (mdl & ~64'h1F));
    rst_n = 1'b0;
    #1;
    check("arst_map",   bus.map_out,       64'd0);
    check("arst_busy",  64'(bus.busy),     64'd1);
    check("arst_ready", 64'(bus.wr_ready), 64'd0);
    check("arst_rdbit", 64'(bus.rd_bit),   64'd0);
    step();
    rst_n = 1'b1;
    wait_load("reload_after_rst");
    check("rst_reload_map", bus.map_out, INIT);
    mdl = INIT;

`ifdef MAZE_PELLET_COUNT_EN
    n_pulse = 0;
    for (int i = 0; i < 64; i++) begin
      if (mdl[i]) do_write("clear_all", i / 8, i % 8, 2'b00);
    end
    step();
    step();
    check("pellets_zero",  64'(bus.pellet_cnt), 64'd0);
    check("all_clear_cnt", 64'(n_pulse),        64'd1);
    check("cleared_map",   bus.map_out,         64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
